// File: rtl/tnn_pkg.sv
// Shared types and helpers for the ternary neuron datapath: activation codes,
// accumulator FSM states and the signed saturating add.
package tnn_pkg;

  localparam logic [1:0] ACT_POS  = 2'b01;
  localparam logic [1:0] ACT_ZERO = 2'b00;
  localparam logic [1:0] ACT_NEG  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ACCUM = 2'b01,
    ST_HOLD  = 2'b10
  } tnn_state_e;

  // Operands arrive sign-extended to 32 bits so one helper serves any acc_w;
  // the sum cannot overflow 32 bits for the widths this datapath uses.
  function automatic logic signed [31:0] sat_add(
    input logic signed [31:0] acc,
    input logic signed [31:0] d,
    input int                 acc_w
  );
    logic signed [31:0] sum;
    logic signed [31:0] max_v;
    logic signed [31:0] min_v;
    sum   = acc + d;
    max_v = (32'sd1 <<< (acc_w - 32'sd1)) - 32'sd1;
    min_v = -(32'sd1 <<< (acc_w - 32'sd1));
    if (sum > max_v) begin
      sat_add = max_v;
    end else if (sum < min_v) begin
      sat_add = min_v;
    end else begin
      sat_add = sum;
    end
  endfunction

endpackage

// File: rtl/tnn_act_compare.sv
// Signed two-threshold compare producing a ternary activation code.
// The upper test wins when the thresholds are inverted.
module tnn_act_compare
  import tnn_pkg::*;
#(
  parameter int ACC_W = 10
) (
  input  logic signed [ACC_W-1:0] sum_i,
  input  logic signed [ACC_W-1:0] thr_hi_i,
  input  logic signed [ACC_W-1:0] thr_lo_i,
  output logic        [1:0]       act_o
);

  // Activation select, upper threshold first
  always_comb begin
    act_o = ACT_ZERO;
    if (sum_i > thr_hi_i) begin
      act_o = ACT_POS;
    end else if (sum_i < thr_lo_i) begin
      act_o = ACT_NEG;
    end else begin
      act_o = ACT_ZERO;
    end
  end

endmodule

// File: rtl/ternary_neuron_accum.sv
// Multi-beat accumulator of (positive - negative) popcounts with saturation,
// closing each evaluation with a thresholded ternary activation.
module ternary_neuron_accum
  import tnn_pkg::*;
#(
  parameter int PC_W      = 5,
  parameter int ACC_W     = 10,
  parameter int MAX_BEATS = 16,
  parameter int CNT_W     = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic        [PC_W-1:0]  in_pos,
  input  logic        [PC_W-1:0]  in_neg,
  input  logic                    in_last,
  input  logic signed [ACC_W-1:0] thr_hi,
  input  logic signed [ACC_W-1:0] thr_lo,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic        [1:0]       out_act,
  output logic signed [ACC_W-1:0] out_sum,
  output logic                    out_ovf
);

  tnn_state_e              state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] thr_hi_q, thr_hi_d, thr_lo_q, thr_lo_d;
  logic signed [ACC_W-1:0] out_sum_q, out_sum_d;
  logic        [CNT_W-1:0] cnt_q, cnt_d;
  logic                    out_valid_q, out_valid_d;
  logic        [1:0]       out_act_q, out_act_d;
  logic                    out_ovf_q, out_ovf_d;

  logic                    accept_s;
  logic signed [PC_W:0]    delta_s;
  logic signed [ACC_W-1:0] acc_base_s, acc_sum_s;
  logic signed [ACC_W-1:0] thr_hi_sel_s, thr_lo_sel_s;
  logic        [CNT_W-1:0] cnt_inc_s;
  logic                    max_hit_s;
  logic        [1:0]       act_s;

  assign in_ready  = (state_q != ST_HOLD) && !rst;
  assign accept_s  = in_valid && in_ready;
  assign delta_s   = $signed({1'b0, in_pos}) - $signed({1'b0, in_neg});
  // The first beat starts from zero and compares against the live thresholds it latches.
  assign acc_base_s   = (state_q == ST_IDLE) ? {ACC_W{1'b0}} : acc_q;
  assign thr_hi_sel_s = (state_q == ST_IDLE) ? thr_hi : thr_hi_q;
  assign thr_lo_sel_s = (state_q == ST_IDLE) ? thr_lo : thr_lo_q;
  assign acc_sum_s    = ACC_W'(sat_add(32'(acc_base_s), 32'(delta_s), ACC_W));
  assign cnt_inc_s    = cnt_q + CNT_W'(1);
  assign max_hit_s    = (cnt_inc_s == CNT_W'(MAX_BEATS));

  tnn_act_compare #(.ACC_W(ACC_W)) u_act_compare (
    .sum_i    (acc_sum_s),
    .thr_hi_i (thr_hi_sel_s),
    .thr_lo_i (thr_lo_sel_s),
    .act_o    (act_s)
  );

  // Next-state and result-capture logic
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    thr_hi_d    = thr_hi_q;
    thr_lo_d    = thr_lo_q;
    out_valid_d = out_valid_q;
    out_act_d   = out_act_q;
    out_sum_d   = out_sum_q;
    out_ovf_d   = out_ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          acc_d    = acc_sum_s;
          cnt_d    = CNT_W'(1);
          thr_hi_d = thr_hi;
          thr_lo_d = thr_lo;
          if (in_last) begin
            state_d     = ST_HOLD;
            out_valid_d = 1'b1;
            out_sum_d   = acc_sum_s;
            out_act_d   = act_s;
            out_ovf_d   = 1'b0;
          end else begin
            state_d = ST_ACCUM;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (accept_s) begin
          acc_d = acc_sum_s;
          cnt_d = cnt_inc_s;
          if (in_last || max_hit_s) begin
            state_d     = ST_HOLD;
            out_valid_d = 1'b1;
            out_sum_d   = acc_sum_s;
            out_act_d   = act_s;
            out_ovf_d   = !in_last;
          end else begin
            state_d = ST_ACCUM;
          end
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_HOLD: begin
        if (out_valid_q && out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          acc_d       = {ACC_W{1'b0}};
          cnt_d       = {CNT_W{1'b0}};
          out_ovf_d   = 1'b0;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= {ACC_W{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      thr_hi_q    <= {ACC_W{1'b0}};
      thr_lo_q    <= {ACC_W{1'b0}};
      out_valid_q <= 1'b0;
      out_act_q   <= ACT_ZERO;
      out_sum_q   <= {ACC_W{1'b0}};
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      thr_hi_q    <= thr_hi_d;
      thr_lo_q    <= thr_lo_d;
      out_valid_q <= out_valid_d;
      out_act_q   <= out_act_d;
      out_sum_q   <= out_sum_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_act   = out_act_q;
  assign out_sum   = out_sum_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_ternary_neuron_accum.sv
// Scoreboard bench for ternary_neuron_accum, built with a narrow accumulator so
// saturation is reachable within the beat limit.
module tb_ternary_neuron_accum;

  localparam int PC_W      = 5;
  localparam int ACC_W     = 6;
  localparam int MAX_BEATS = 16;
  localparam int CNT_W     = 5;
  localparam int SAT_MAX   = 31;
  localparam int SAT_MIN   = -32;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    in_valid;
  logic                    in_ready;
  logic        [PC_W-1:0]  in_pos;
  logic        [PC_W-1:0]  in_neg;
  logic                    in_last;
  logic signed [ACC_W-1:0] thr_hi;
  logic signed [ACC_W-1:0] thr_lo;
  logic                    out_valid;
  logic                    out_ready;
  logic        [1:0]       out_act;
  logic signed [ACC_W-1:0] out_sum;
  logic                    out_ovf;

  always #5 clk = ~clk;

  ternary_neuron_accum #(
    .PC_W(PC_W), .ACC_W(ACC_W), .MAX_BEATS(MAX_BEATS), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pos(in_pos), .in_neg(in_neg), .in_last(in_last),
    .thr_hi(thr_hi), .thr_lo(thr_lo),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_act(out_act), .out_sum(out_sum), .out_ovf(out_ovf)
  );

  typedef struct {
    int sum;
    int act;
    int ovf;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   m_acc = 0;
  int   m_cnt = 0;
  int   m_hi  = 0;
  int   m_lo  = 0;

  function automatic int clamp(input int v);
    if (v > SAT_MAX) return SAT_MAX;
    if (v < SAT_MIN) return SAT_MIN;
    return v;
  endfunction

  function automatic int act_of(input int s, input int hi, input int lo);
    if (s > hi) return 1;
    if (s < lo) return 3;
    return 0;
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send_beat(input int pos, input int neg, input bit last,
                           input int hi, input int lo);
    exp_t e;
    bit   done;
    @(negedge clk);
    in_valid = 1'b1;
    in_pos   = PC_W'(pos);
    in_neg   = PC_W'(neg);
    in_last  = last;
    thr_hi   = ACC_W'(hi);
    thr_lo   = ACC_W'(lo);
    for (int i = 0; i < 40 && !in_ready; i++) @(negedge clk);
    check("ready_wait", int'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (m_cnt == 0) begin
      m_hi  = hi;
      m_lo  = lo;
      m_acc = clamp(pos - neg);
      m_cnt = 1;
    end else begin
      m_acc = clamp(m_acc + pos - neg);
      m_cnt = m_cnt + 1;
    end
    done = last || (m_cnt == MAX_BEATS);
    if (done) begin
      e.sum = m_acc;
      e.act = act_of(m_acc, m_hi, m_lo);
      e.ovf = (!last) ? 1 : 0;
      sb_q.push_back(e);
      m_acc = 0;
      m_cnt = 0;
      check("latency_valid", int'(out_valid), 1);
    end else begin
      check("early_valid", int'(out_valid), 0);
    end
  endtask

  task automatic collect();
    exp_t e;
    @(negedge clk);
    for (int i = 0; i < 40 && !out_valid; i++) @(negedge clk);
    check("valid_wait", int'(out_valid), 1);
    if (sb_q.size() == 0) begin
      check("sb_size", sb_q.size(), 1);
      e.sum = 0;
      e.act = 0;
      e.ovf = 0;
    end else begin
      e = sb_q.pop_front();
      check("out_sum", int'(out_sum), e.sum);
      check("out_act", int'(out_act), e.act);
      check("out_ovf", int'(out_ovf), e.ovf);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("valid_drop", int'(out_valid), 0);
    check("ready_back", int'(in_ready), 1);
    check("sum_kept", int'(out_sum), e.sum);
    check("act_kept", int'(out_act), e.act);
    check("ovf_clear", int'(out_ovf), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_pos    = '0;
    in_neg    = '0;
    in_last   = 1'b0;
    thr_hi    = '0;
    thr_lo    = '0;
    out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_sum", int'(out_sum), 0);
    check("rst_out_act", int'(out_act), 0);
    check("rst_out_ovf", int'(out_ovf), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_ready", int'(in_ready), 1);

    // single beat
    send_beat(20, 3, 1'b1, 10, -10);
    collect();

    // three back-to-back beats
    send_beat(5, 9, 1'b0, 0, -5);
    send_beat(0, 12, 1'b0, 0, -5);
    send_beat(7, 7, 1'b1, 0, -5);
    collect();

    // same with gaps; later threshold values must be ignored
    send_beat(5, 9, 1'b0, 0, -5);
    repeat (2) @(negedge clk);
    send_beat(0, 12, 1'b0, 20, -20);
    repeat (2) @(negedge clk);
    send_beat(7, 7, 1'b1, 20, -20);
    collect();

    // positive and negative saturation, then recovery from the clamp
    send_beat(31, 0, 1'b0, 30, 0);
    send_beat(31, 0, 1'b0, 30, 0);
    send_beat(31, 0, 1'b1, 30, 0);
    collect();
    send_beat(0, 31, 1'b0, 0, -31);
    send_beat(0, 31, 1'b1, 0, -31);
    collect();
    send_beat(31, 0, 1'b0, 0, 0);
    send_beat(31, 0, 1'b0, 0, 0);
    send_beat(0, 5, 1'b1, 0, 0);
    collect();

    // forced completion at MAX_BEATS, then backpressure with in_valid high
    for (int i = 0; i < MAX_BEATS; i++) send_beat(1, 0, 1'b0, 10, -10);
    @(negedge clk);
    in_valid = 1'b1;
    in_pos   = PC_W'(3);
    in_neg   = PC_W'(0);
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_out_sum", int'(out_sum), 16);
      check("bp_out_ovf", int'(out_ovf), 1);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    collect();
    send_beat(2, 0, 1'b1, 5, -5);
    collect();

    // reset during accumulation
    send_beat(3, 0, 1'b0, 1, -1);
    send_beat(3, 0, 1'b0, 1, -1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_valid", int'(out_valid), 0);
    check("mid_rst_ready", int'(in_ready), 0);
    @(negedge clk);
    rst   = 1'b0;
    m_acc = 0;
    m_cnt = 0;
    send_beat(4, 4, 1'b1, 1, -1);
    collect();

    // reset while holding a result discards it
    send_beat(10, 0, 1'b1, 1, -1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("hold_rst_valid", int'(out_valid), 0);
    check("hold_rst_sum", int'(out_sum), 0);
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;

    // sums equal to a threshold give zero activation
    send_beat(1, 2, 1'b1, 1, -1);
    collect();
    send_beat(1, 0, 1'b1, 1, -1);
    collect();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
